wb_fabric_decoder: RTL and testbench

WB_FABRIC_DECODER -- requirements
Module: wb_fabric_decoder

---
 rtl/wb_fabric_decoder_pkg.sv | 36 +++
 rtl/wb_fabric_decoder_timeout.sv | 27 ++
 rtl/wb_fabric_decoder.sv | 143 ++++++++++++++
 tb/tb_wb_fabric_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fabric_decoder_pkg.sv
// Shared types and constants for the Wishbone fabric decoder.
// Slot map: four 1 KiB slots at the bottom of the 128 KiB window.
package wb_fabric_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLOT_CNT = 4;

  localparam logic [SLOT_CNT-1:0][16:0] SLOT_BASE = {
    17'h00C00,
    17'h00800,
    17'h00400,
    17'h00000
  };

  localparam logic [31:0] DEF_RD_VALUE_C = 32'hFABDEFAC;

  // Returns {hit, slot}; a slot spans the low 10 address bits.
  function automatic logic [2:0] slot_decode(
    input logic [16:0] adr
  );
    logic [2:0] v_res;
    v_res = 3'b000;
    for (int k = 0; k < SLOT_CNT; k++) begin
      if (adr[16:10] == SLOT_BASE[k][16:10]) begin
        v_res = {1'b1, 2'(k)};
      end
    end
    return v_res;
  endfunction

endpackage

// File: rtl/wb_fabric_decoder_timeout.sv
// Wait-cycle watchdog for the fabric decoder.
// Built only when WB_FABRIC_TIMEOUT_EN is defined.
module wb_fabric_timeout #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == TIMEOUT_CYC - 8'd1);

endmodule

// File: rtl/wb_fabric_decoder.sv
// Wishbone 1-to-4 address decoder with registered ACK/data return.
// Optional slave watchdog enabled by macro WB_FABRIC_TIMEOUT_EN.
module wb_fabric_decoder
  import wb_fabric_decoder_pkg::*;
#(
  parameter logic [7:0]  TIMEOUT_CYC  = 8'd64,
  parameter logic [31:0] DEF_RD_VALUE = DEF_RD_VALUE_C
) (
  input  logic         WBs_CLK_i,
  input  logic         WBs_RST_n_i,
  input  logic [16:0]  WBm_ADR_i,
  input  logic         WBm_CYC_i,
  input  logic         WBm_STB_i,
  input  logic         WBm_WE_i,
  input  logic [3:0]   WBm_BYTE_STB_i,
  input  logic [31:0]  WBm_DAT_i,
  output logic [31:0]  WBm_DAT_o,
  output logic         WBm_ACK_o,
  output logic [3:0]   WBs_CYC_o,
  output logic         WBs_STB_o,
  output logic         WBs_WE_o,
  output logic [16:0]  WBs_ADR_o,
  output logic [3:0]   WBs_BYTE_STB_o,
  output logic [31:0]  WBs_DAT_o,
  input  logic [127:0] WBs_DAT_i,
  input  logic [3:0]   WBs_ACK_i,
  output logic         Bus_Err_o,
  output logic [7:0]   Timeout_Cnt_o
);

  state_e      r_state;
  logic [1:0]  r_slot;
  logic [31:0] r_dat;
  logic        r_ack;
  logic        r_err;

  logic        w_req;
  logic        w_hit;
  logic [1:0]  w_dec_slot;
  logic        w_start;
  logic        w_sel_ack;
  logic [31:0] w_sel_dat;

  assign w_req = WBm_CYC_i & WBm_STB_i;
  assign {w_hit, w_dec_slot} = slot_decode(WBm_ADR_i);
  assign w_start = (r_state == ST_IDLE) & w_req & w_hit;
  assign w_sel_ack = WBs_ACK_i[r_slot];
  assign w_sel_dat = WBs_DAT_i[{r_slot, 5'd0} +: 32];

  assign WBs_STB_o      = WBm_STB_i;
  assign WBs_WE_o       = WBm_WE_i;
  assign WBs_ADR_o      = WBm_ADR_i;
  assign WBs_BYTE_STB_o = WBm_BYTE_STB_i;
  assign WBs_DAT_o      = WBm_DAT_i;

  assign WBm_DAT_o = r_dat;
  assign WBm_ACK_o = r_ack;
  assign Bus_Err_o = r_err;

  always_comb begin
    WBs_CYC_o = 4'b0000;
    if (r_state == ST_IDLE && w_hit) begin
      WBs_CYC_o[w_dec_slot] = w_req;
    end else if (r_state == ST_WAIT) begin
      WBs_CYC_o[r_slot] = w_req;
    end
  end

`ifdef WB_FABRIC_TIMEOUT_EN
  logic       w_expire;
  logic [7:0] r_to_cnt;

  wb_fabric_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (WBs_CLK_i),
    .rst_n    (WBs_RST_n_i),
    .i_clr    (w_start),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  assign Timeout_Cnt_o = r_to_cnt;
`else
  // Watchdog absent: count is tied off, parameter kept for API parity.
  assign Timeout_Cnt_o = TIMEOUT_CYC & 8'h00;
`endif

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_state  <= ST_IDLE;
      r_slot   <= 2'd0;
      r_dat    <= 32'd0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
`ifdef WB_FABRIC_TIMEOUT_EN
      r_to_cnt <= 8'd0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_WAIT;
            r_slot  <= w_dec_slot;
          end else if (w_req) begin
            r_state <= ST_DONE;
            r_dat   <= DEF_RD_VALUE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!WBm_CYC_i) begin
            r_state <= ST_IDLE;
          end else if (w_sel_ack) begin
            r_state <= ST_DONE;
            r_dat   <= w_sel_dat;
            r_ack   <= 1'b1;
`ifdef WB_FABRIC_TIMEOUT_EN
          end else if (w_expire) begin
            r_state <= ST_DONE;
            r_dat   <= DEF_RD_VALUE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            if (r_to_cnt != 8'hFF) begin
              r_to_cnt <= r_to_cnt + 8'd1;
            end
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fabric_decoder.sv
// Self-checking bench for wb_fabric_decoder (default and
// WB_FABRIC_TIMEOUT_EN builds), transaction-level reference model.
module tb_wb_fabric_decoder;

  localparam logic [31:0] DEF = 32'hFABDEFAC;
  localparam int TO = 64;
`ifdef WB_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [16:0]  m_adr = '0;
  logic         m_cyc = 1'b0;
  logic         m_stb = 1'b0;
  logic         m_we = 1'b0;
  logic [3:0]   m_sel = '0;
  logic [31:0]  m_wdat = '0;
  logic [31:0]  m_rdat;
  logic         m_ack;
  logic [3:0]   s_cyc;
  logic         s_stb;
  logic         s_we;
  logic [16:0]  s_adr;
  logic [3:0]   s_sel;
  logic [31:0]  s_wdat;
  logic [127:0] s_dat = '0;
  logic [3:0]   s_ack = '0;
  logic         err;
  logic [7:0]   to_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: last returned data and timeout tally.
  logic [31:0] exp_dat = 32'd0;
  int          exp_to = 0;

  always #5 clk = ~clk;

  wb_fabric_decoder #(
    .TIMEOUT_CYC  (8'd64),
    .DEF_RD_VALUE (DEF)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_n_i    (rst_n),
    .WBm_ADR_i      (m_adr),
    .WBm_CYC_i      (m_cyc),
    .WBm_STB_i      (m_stb),
    .WBm_WE_i       (m_we),
    .WBm_BYTE_STB_i (m_sel),
    .WBm_DAT_i      (m_wdat),
    .WBm_DAT_o      (m_rdat),
    .WBm_ACK_o      (m_ack),
    .WBs_CYC_o      (s_cyc),
    .WBs_STB_o      (s_stb),
    .WBs_WE_o       (s_we),
    .WBs_ADR_o      (s_adr),
    .WBs_BYTE_STB_o (s_sel),
    .WBs_DAT_o      (s_wdat),
    .WBs_DAT_i      (s_dat),
    .WBs_ACK_i      (s_ack),
    .Bus_Err_o      (err),
    .Timeout_Cnt_o  (to_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"}, {31'd0, m_ack}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_dat"}, m_rdat, exp_dat);
    chk({tag, "_tocnt"}, {24'd0, to_cnt}, 32'(exp_to));
  endtask

  // dly: WAIT cycle in which the slave ACKs (-1: never).
  task automatic xfer(input logic [16:0] adr, input logic we,
                      input int dly, input logic [31:0] sdat,
                      input logic spur);
    logic hit;
    int slot;
    int w;
    logic tmo;
    logic [3:0] sp;
    logic [31:0] exp_cyc;
    hit = (adr >> 12) == 17'd0;
    slot = int'(adr[11:10]);
    exp_cyc = hit ? (32'd1 << slot) : 32'd0;
    @(posedge clk); #1;
    m_adr = adr; m_we = we;
    m_sel = 4'($urandom); m_wdat = $urandom;
    m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0;
    s_dat = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("pass_ctl", {9'd0, s_stb, s_we, s_sel, s_adr},
        {9'd0, 1'b1, we, m_sel, adr});
    chk("pass_dat", s_wdat, m_wdat);
    chk("cyc_req", {28'd0, s_cyc}, exp_cyc);
    if (hit) begin
      if (dly >= 0 && (!TO_EN || dly < TO)) begin
        w = dly; tmo = 1'b0;
      end else begin
        w = TO - 1; tmo = 1'b1;
      end
      for (int i = 0; i <= w; i++) begin
        @(posedge clk); #1;
        sp = spur ? 4'($urandom) : 4'd0;
        sp[slot] = 1'b0;
        s_ack = sp;
        if (!tmo && i == w) begin
          s_ack[slot] = 1'b1;
          s_dat[32*slot +: 32] = sdat;
        end
        @(negedge clk);
        chk("wait_ack", {31'd0, m_ack}, 32'd0);
        chk("wait_cyc", {28'd0, s_cyc}, exp_cyc);
      end
      @(posedge clk); #1;
      s_ack = spur ? 4'($urandom) : 4'd0;
      exp_dat = tmo ? DEF : sdat;
      if (tmo && exp_to < 255) exp_to++;
      @(negedge clk);
      chk("done_err", {31'd0, err}, {31'd0, tmo});
    end else begin
      exp_dat = DEF;
      @(negedge clk);
      chk("done_err", {31'd0, err}, 32'd1);
    end
    chk("done_ack", {31'd0, m_ack}, 32'd1);
    chk("done_dat", m_rdat, exp_dat);
    chk("done_cyc", {28'd0, s_cyc}, 32'd0);
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    @(negedge clk);
    chk_idle("post");
  endtask

  // Sits k cycles in WAIT, then drops CYC or asserts reset.
  task automatic abandon(input int slot, input int k,
                         input logic use_rst);
    @(posedge clk); #1;
    m_adr = 17'(slot * 1024) + 17'($urandom_range(0, 1023));
    m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0;
    @(posedge clk);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("ab_wait_ack", {31'd0, m_ack}, 32'd0);
      @(posedge clk);
    end
    #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    if (use_rst) begin
      rst_n = 1'b0;
      exp_dat = 32'd0;
      exp_to = 0;
    end
    @(negedge clk);
    chk("ab_cyc", {28'd0, s_cyc}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk_idle("ab");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
    end
    chk_idle("ab_end");
  endtask

  initial begin
    logic [16:0] a;
    int d;
    // Reset state
    #2;
    @(negedge clk);
    chk("rst_cyc", {28'd0, s_cyc}, 32'd0);
    chk_idle("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rel");

    // Slot 1 read, slave ACKs two cycles after request
    xfer(17'h00404, 1'b0, 1, 32'hA5A5_0001, 1'b0);
    // Unmapped read
    xfer(17'h01000, 1'b0, 0, 32'h0, 1'b0);
    // Slot 3 with spurious ACKs from other slots
    xfer(17'h00C10, 1'b0, 4, 32'h3333_CAFE, 1'b1);
    // Write handshake, slot 0, immediate ACK
    xfer(17'h00008, 1'b1, 0, 32'h0000_BEEF, 1'b0);
    // Master abort and reset in WAIT, each followed by a normal access
    abandon(1, 3, 1'b0);
    xfer(17'h00420, 1'b0, 2, 32'h1234_5678, 1'b0);
    abandon(2, 5, 1'b1);
    xfer(17'h00800, 1'b0, 0, 32'h8765_4321, 1'b0);

`ifdef WB_FABRIC_TIMEOUT_EN
    xfer(17'h00800, 1'b0, -1, 32'h0, 1'b0);
    xfer(17'h00C00, 1'b0, TO - 1, 32'h5EED_0003, 1'b1);
    xfer(17'h00C04, 1'b0, TO - 2, 32'h5EED_0004, 1'b0);
    for (int n = 0; n < 300; n++) begin
      xfer(17'h00800, 1'b0, -1, 32'h0, 1'b0);
    end
`endif

    // Randomized mix of mapped/unmapped accesses and aborts
    for (int n = 0; n < 60; n++) begin
      a = 17'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        a[16:12] = 5'd0;
      end else begin
        a[16:12] = 5'($urandom_range(1, 31));
      end
      d = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) begin
        abandon($urandom_range(0, 3), d, 1'($urandom));
      end else begin
        xfer(a, 1'($urandom), d, $urandom, 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
